hwpe_stream_sidech_rr_arbiter: RTL and testbench
================================================

HWPE_STREAM_SIDECH_RR_ARBITER -- requirements
Module: hwpe_stream_sidech_rr_arbiter

Interface
REQ-001 SHALL have parameter NB_IN, default 2, number of requesting streams (>=2).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, stream data width; strb width is DATA_WIDTH/8.
REQ-003 SHALL have parameter SIDECH_WIDTH, default 1, side-channel width per stream.
REQ-004 SHALL have parameter MAX_BURST, default 4, max beats per grant (>=1).
REQ-005 SHALL have parameter EOP_ON_SIDECH, default 1; if 1, side-channel MSB marks end-of-packet.
REQ-006 SHALL have clk_i  input  1  single clock, rising edge.
REQ-007 SHALL have rst_ni  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have clear_i  input  1  synchronous clear, active-high.
REQ-009 SHALL have push_i  hwpe_stream_intf_stream.sink array  NB_IN  requesting streams (valid/ready/data/strb).
REQ-010 SHALL have sidech_i  input  NB_IN x SIDECH_WIDTH  side channel, qualified by push_i[k].valid.
REQ-011 SHALL have pop_o  hwpe_stream_intf_stream.source  1  arbitrated output stream.
REQ-012 SHALL have sidech_o  output  SIDECH_WIDTH  side channel of forwarded beat.
REQ-013 SHALL have grant_id_o  output  max(1,clog2(NB_IN))  index of granted stream.
REQ-014 SHALL have busy_o  output  1  high while a grant is held.

Function
REQ-015 SHALL implement FSM states IDLE, GRANT plus registers grant_q, rr_ptr_q (range 0..NB_IN-1), beat_cnt_q (range 0..MAX_BURST-1).
REQ-016 Arbitration: winner = first k with push_i[k].valid=1, searching rr_ptr_q, rr_ptr_q+1, ... modulo NB_IN.
REQ-017 IDLE: pop_o.valid=0, all push_i[k].ready=0; if any valid, next state GRANT, grant_q=winner, beat_cnt_q=0; arbitration latency exactly 1 cycle.
REQ-018 GRANT: pop_o.valid/data/strb and sidech_o combinationally mirror push_i[grant_q]/sidech_i[grant_q]; push_i[grant_q].ready=pop_o.ready; all other ready=0.
REQ-019 Handshake = pop_o.valid & pop_o.ready in GRANT; each handshake increments beat_cnt_q.
REQ-020 Release condition in GRANT: (handshake AND (beat_cnt_q==MAX_BURST-1 OR (EOP_ON_SIDECH==1 AND sidech_i[grant_q][SIDECH_WIDTH-1]==1))) OR push_i[grant_q].valid==0.
REQ-021 On release: rr_ptr_q=(grant_q+1) mod NB_IN; arbitration per REQ-016 runs in the same cycle with rr_ptr=(grant_q+1) mod NB_IN, excluding grant_q only if its beat was not just accepted AND its valid is 0.
REQ-022 On release with a winner: stay GRANT, grant_q=winner, beat_cnt_q=0 (zero-bubble handover); with no winner: go IDLE.
REQ-023 Without release in GRANT: state, grant_q held; beat_cnt_q updated per REQ-019.
REQ-024 pop_o.data, pop_o.strb, sidech_o SHALL be '0 whenever pop_o.valid=0.
REQ-025 grant_id_o=grant_q; busy_o=1 iff state==GRANT.
REQ-026 Back-pressure (pop_o.ready=0) SHALL hold grant and beat_cnt_q indefinitely; no beat dropped or duplicated.
REQ-027 Single-requester case: same stream regranted back-to-back with no bubble; max MAX_BURST beats per grant.
REQ-028 Beat ordering per input SHALL be preserved; data/strb/sidech SHALL pass unmodified.

Reset
REQ-029 rst_ni=0 SHALL asynchronously force IDLE, grant_q=0, rr_ptr_q=0, beat_cnt_q=0; pop_o.valid=0, data/strb/sidech_o=0, grant_id_o=0, busy_o=0, all push ready=0.
REQ-030 clear_i=1 at a clock edge SHALL produce the same register state as REQ-029; mid-burst clear abandons the grant, no beat of that cycle is accepted (all ready=0 while clear_i=1).

Verification
REQ-031 NB_IN=3, MAX_BURST=4, all three valid continuously, pop_o.ready=1, no EOP -> grant_id_o sequence 0,1,2,0 with 4 beats each, busy_o stays 1, no bubble after the first cycle.
REQ-032 Only stream 1 valid, 10 beats, ready=1 -> beats 4+4+2, grant_id_o=1 throughout, output data order identical to input.
REQ-033 Stream 0 sends beat with sidech MSB=1 on beat 2, stream 2 valid -> grant moves to 2 on next cycle after beat 2, beat_cnt restarts at 0.
REQ-034 pop_o.ready=0 for 5 cycles mid-burst -> push_i[grant].ready=0, grant_id_o and pop_o.data stable, no beat lost.
REQ-035 Stream 2 drops valid mid-burst while stream 0 valid -> release, stream 0 granted next cycle, pop_o.data=0 while pop_o.valid=0.
REQ-036 rst_ni pulsed low mid-burst (and separately clear_i=1) -> all outputs 0 immediately (reset) or next edge (clear); first grant afterwards goes to lowest-index valid stream.

Source files
------------

// File: rtl/hwpe_stream_sidech_rr_arbiter_if.sv
// Stream interface: a beat moves only in a cycle where valid and ready are both high.
interface hwpe_stream_intf_stream #(
    parameter int unsigned DATA_WIDTH = 32
);
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;
    logic [STRB_WIDTH-1:0] strb;

    modport source (output valid, data, strb, input ready);
    modport sink   (input valid, data, strb, output ready);
endinterface

// File: rtl/hwpe_stream_sidech_rr_arbiter.sv
// Round-robin arbiter that forwards one of NB_IN streams, plus a per-stream
// side channel, to a single output. A grant lasts up to MAX_BURST beats, ends
// early on an end-of-packet side-channel bit or when the granted source drops
// valid, and hands over to the next requester in the same cycle.
module hwpe_stream_sidech_rr_arbiter #(
    parameter int unsigned NB_IN         = 2,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned SIDECH_WIDTH  = 1,
    parameter int unsigned MAX_BURST     = 4,
    parameter int unsigned EOP_ON_SIDECH = 1,
    localparam int unsigned ID_W         = (NB_IN > 1) ? $clog2(NB_IN) : 1
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                clear_i,
    hwpe_stream_intf_stream.sink                push_i [NB_IN-1:0],
    input  logic [NB_IN-1:0][SIDECH_WIDTH-1:0]  sidech_i,
    hwpe_stream_intf_stream.source              pop_o,
    output logic [SIDECH_WIDTH-1:0]             sidech_o,
    output logic [ID_W-1:0]                     grant_id_o,
    output logic                                busy_o
);

    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam int unsigned CNT_W  = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam int unsigned IDX_W  = ID_W + 1;

    // Handshake semantics: a beat transfers on a rising edge where valid and
    // ready are both high; valid/data/strb/sidech of an input are held by the
    // source until that happens, and ready never depends on anything but the
    // grant state and pop_o.ready.

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t             state_q;
    logic [ID_W-1:0]    grant_q;
    logic [ID_W-1:0]    rr_ptr_q;
    logic [CNT_W-1:0]   beat_cnt_q;

    logic [NB_IN-1:0]       in_valid;
    logic [NB_IN-1:0]       in_ready;
    logic [DATA_WIDTH-1:0]  in_data [NB_IN];
    logic [STRB_W-1:0]      in_strb [NB_IN];

    logic               active;
    logic               g_valid;
    logic               pop_valid;
    logic               handshake;
    logic               eop;
    logic               last_beat;
    logic               release_grant;
    logic [ID_W-1:0]    next_ptr;
    logic [ID_W-1:0]    arb_start;
    logic               arb_found;
    logic [ID_W-1:0]    arb_win;

    // Flatten the interface array so it can be indexed by the grant register.
    for (genvar k = 0; k < NB_IN; k++) begin : g_unpack
        assign in_valid[k]     = push_i[k].valid;
        assign in_data[k]      = push_i[k].data;
        assign in_strb[k]      = push_i[k].strb;
        assign push_i[k].ready = in_ready[k];
    end

    // First requester at or after start, wrapping modulo NB_IN.
    function automatic logic [ID_W:0] rr_pick(input logic [ID_W-1:0] start,
                                              input logic [NB_IN-1:0] req);
        logic [IDX_W-1:0] idx;
        logic             found;
        logic [ID_W-1:0]  win;
        found = 1'b0;
        win   = '0;
        for (int unsigned i = 0; i < NB_IN; i++) begin
            idx = {1'b0, start} + IDX_W'(i);
            if (idx >= IDX_W'(NB_IN)) begin
                idx = idx - IDX_W'(NB_IN);
            end
            if (!found && req[idx[ID_W-1:0]]) begin
                found = 1'b1;
                win   = idx[ID_W-1:0];
            end
        end
        return {found, win};
    endfunction

    assign active        = (state_q == GRANT) && !clear_i;
    assign g_valid       = in_valid[grant_q];
    assign pop_valid     = active && g_valid;
    assign handshake     = pop_valid && pop_o.ready;
    assign eop           = (EOP_ON_SIDECH != 0) && sidech_i[grant_q][SIDECH_WIDTH-1];
    assign last_beat     = (beat_cnt_q == CNT_W'(MAX_BURST - 1));
    assign release_grant = (handshake && (last_beat || eop)) || !g_valid;
    assign next_ptr      = (grant_q == ID_W'(NB_IN - 1)) ? '0 : grant_q + ID_W'(1);
    assign arb_start     = (state_q == GRANT) ? next_ptr : rr_ptr_q;
    assign {arb_found, arb_win} = rr_pick(arb_start, in_valid);

    // Output path mirrors the granted input; payload is zeroed when not valid.
    assign pop_o.valid = pop_valid;
    assign pop_o.data  = pop_valid ? in_data[grant_q]  : '0;
    assign pop_o.strb  = pop_valid ? in_strb[grant_q]  : '0;
    assign sidech_o    = pop_valid ? sidech_i[grant_q] : '0;
    assign grant_id_o  = grant_q;
    // busy_o is the FSM state itself (GRANT vs IDLE).
    assign busy_o      = (state_q == GRANT);

    // Only the granted input sees the downstream ready; none during clear.
    always_comb begin
        in_ready = '0;
        if (active) begin
            in_ready[grant_q] = pop_o.ready;
        end
    end

    // Grant FSM: arbitration, burst counting and zero-bubble handover.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else if (clear_i) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else if (state_q == IDLE) begin
            if (arb_found) begin
                state_q    <= GRANT;
                grant_q    <= arb_win;
                beat_cnt_q <= '0;
            end
        end else begin
            if (release_grant) begin
                rr_ptr_q   <= next_ptr;
                beat_cnt_q <= '0;
                if (arb_found) begin
                    grant_q <= arb_win;
                end else begin
                    state_q <= IDLE;
                end
            end else if (handshake) begin
                beat_cnt_q <= beat_cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hwpe_stream_sidech_rr_arbiter.sv
// Bench for the side-channel round-robin arbiter: directed scenarios with
// literal expectations, then randomized traffic against a queue-based model.
module tb_hwpe_stream_sidech_rr_arbiter;

  localparam int NB  = 3;
  localparam int DW  = 32;
  localparam int SB  = DW / 8;
  localparam int SW  = 2;
  localparam int MB  = 4;
  localparam int IDW = 2;
  localparam int BW  = SW + SB + DW;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;
  always #5 clk = ~clk;

  hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) push_if [NB-1:0] ();
  hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) pop_if ();

  logic [NB-1:0]         drv_valid;
  logic [DW-1:0]         drv_data [NB];
  logic [SB-1:0]         drv_strb [NB];
  logic [NB-1:0][SW-1:0] drv_sidech;
  logic                  drv_pop_ready;
  logic [NB-1:0]         obs_ready;
  logic [SW-1:0]         obs_sidech;
  logic [IDW-1:0]        obs_gid;
  logic                  obs_busy;

  for (genvar g = 0; g < NB; g++) begin : g_push
    assign push_if[g].valid = drv_valid[g];
    assign push_if[g].data  = drv_data[g];
    assign push_if[g].strb  = drv_strb[g];
    assign obs_ready[g]     = push_if[g].ready;
  end
  assign pop_if.ready = drv_pop_ready;

  hwpe_stream_sidech_rr_arbiter #(
    .NB_IN(NB), .DATA_WIDTH(DW), .SIDECH_WIDTH(SW), .MAX_BURST(MB), .EOP_ON_SIDECH(1)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
    .push_i(push_if), .sidech_i(drv_sidech),
    .pop_o(pop_if), .sidech_o(obs_sidech),
    .grant_id_o(obs_gid), .busy_o(obs_busy)
  );

  // stimulus controls
  logic [NB-1:0] en;
  logic          ready_ctl;
  logic          clear_ctl;
  int            eop_pct;
  int            seq [NB];

  // source queues and scoreboard
  logic [BW-1:0] src_q [NB][$];
  logic [BW-1:0] exp_q[$];

  // behavioural model: who holds the grant, where the search starts next,
  // and how many beats the current holder has moved
  bit m_busy;
  int m_grant;
  int m_ptr;
  int m_taken;

  // per-step observations for the directed expectations
  logic [IDW-1:0] last_gid;
  logic           last_busy;
  logic           last_pop_valid;
  logic [DW-1:0]  last_pop_data;
  logic [NB-1:0]  last_ready;
  int             hs_total;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int pick(int start, logic [NB-1:0] req);
    for (int off = 0; off < NB; off++) begin
      int idx;
      idx = (start + off) % NB;
      if (req[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [BW-1:0] make_beat(int k, bit eop);
    logic [DW-1:0] d;
    d = {4'(k), 12'(seq[k]), 16'($urandom)};
    seq[k]++;
    return {eop, 1'($urandom), 4'($urandom), d};
  endfunction

  task automatic push_beats(int k, int n, int eop_idx);
    for (int i = 0; i < n; i++) begin
      bit e;
      e = (i == eop_idx) || (int'($urandom_range(99)) < eop_pct);
      src_q[k].push_back(make_beat(k, e));
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_grant = 0; m_ptr = 0; m_taken = 0;
  endtask

  // One clock cycle: drive at negedge, compare against the model, advance it.
  task automatic step();
    logic [NB-1:0] v;
    logic          exp_valid;
    logic [NB-1:0] exp_ready;
    logic [BW-1:0] cur;
    logic [BW-1:0] got;
    bit            hs;
    bit            rel;
    int            w;
    @(negedge clk);
    clear = clear_ctl;
    drv_pop_ready = ready_ctl;
    for (int k = 0; k < NB; k++) begin
      v[k] = en[k] && (src_q[k].size() > 0);
      drv_valid[k] = v[k];
      if (v[k]) begin
        {drv_sidech[k], drv_strb[k], drv_data[k]} = src_q[k][0];
      end else begin
        drv_data[k] = $urandom;
        drv_strb[k] = 4'($urandom);
        drv_sidech[k] = 2'($urandom);
      end
    end
    #1;
    exp_valid = m_busy && !clear_ctl && v[m_grant];
    exp_ready = '0;
    if (m_busy && !clear_ctl && ready_ctl) exp_ready[m_grant] = 1'b1;
    hs = exp_valid && ready_ctl;
    cur = exp_valid ? src_q[m_grant][0] : '0;
    if (hs) exp_q.push_back(cur);
    got = {obs_sidech, pop_if.strb, pop_if.data};

    check("busy", 64'(obs_busy), 64'(m_busy));
    check("grant_id", 64'(obs_gid), 64'(m_grant));
    check("pop_valid", 64'(pop_if.valid), 64'(exp_valid));
    check("push_ready", 64'(obs_ready), 64'(exp_ready));
    if (!pop_if.valid) check("idle_payload_zero", 64'(got), 64'(0));
    if (exp_valid) check("fwd_beat", 64'(got), 64'(cur));
    if (pop_if.valid && ready_ctl) begin
      if (exp_q.size() == 0) check("unexpected_beat", 64'(1), 64'(0));
      else check("sb_beat", 64'(got), 64'(exp_q.pop_front()));
      hs_total++;
    end

    last_gid = obs_gid; last_busy = obs_busy; last_pop_valid = pop_if.valid;
    last_pop_data = pop_if.data; last_ready = obs_ready;

    if (clear_ctl) begin
      model_reset();
    end else if (!m_busy) begin
      w = pick(m_ptr, v);
      if (w >= 0) begin m_busy = 1; m_grant = w; m_taken = 0; end
    end else begin
      if (hs) begin
        void'(src_q[m_grant].pop_front());
        m_taken++;
      end
      rel = (hs && (m_taken == MB || cur[BW-1])) || !v[m_grant];
      if (rel) begin
        m_ptr = (m_grant + 1) % NB;
        m_taken = 0;
        w = pick(m_ptr, v);
        if (w < 0) m_busy = 0;
        else m_grant = w;
      end
    end
  endtask

  task automatic restart();
    @(negedge clk);
    rst_n = 1'b0; drv_valid = '0; clear = 1'b0;
    clear_ctl = 0; en = '0; ready_ctl = 1; eop_pct = 0;
    for (int k = 0; k < NB; k++) src_q[k].delete();
    exp_q.delete();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic async_reset_mid(string tag);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check({tag, "_busy"}, 64'(obs_busy), 64'(0));
    check({tag, "_gid"}, 64'(obs_gid), 64'(0));
    check({tag, "_pop_valid"}, 64'(pop_if.valid), 64'(0));
    check({tag, "_payload"}, 64'({obs_sidech, pop_if.strb, pop_if.data}), 64'(0));
    check({tag, "_ready"}, 64'(obs_ready), 64'(0));
    model_reset();
    drv_valid = '0; clear = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int gid_log [16];
    logic busy_log [16];
    logic pv_log [16];
    int n, hs0;
    logic [DW-1:0] held;

    drv_valid = '0; drv_pop_ready = 1'b0; drv_sidech = '0;
    for (int k = 0; k < NB; k++) begin drv_data[k] = '0; drv_strb[k] = '0; seq[k] = 0; end
    en = '0; ready_ctl = 1; clear_ctl = 0; eop_pct = 0; hs_total = 0;
    model_reset();

    // all three requesting, no EOP: 4 beats each in order 0,1,2,0
    restart();
    for (int k = 0; k < NB; k++) push_beats(k, 20, -1);
    en = '1;
    for (int s = 0; s < 14; s++) begin
      step(); gid_log[s] = int'(last_gid); busy_log[s] = last_busy; pv_log[s] = last_pop_valid;
    end
    check("s1_busy_c0", 64'(busy_log[0]), 64'(0));
    check("s1_gid_c1", 64'(gid_log[1]), 64'(0));
    check("s1_gid_c4", 64'(gid_log[4]), 64'(0));
    check("s1_gid_c5", 64'(gid_log[5]), 64'(1));
    check("s1_gid_c8", 64'(gid_log[8]), 64'(1));
    check("s1_gid_c9", 64'(gid_log[9]), 64'(2));
    check("s1_gid_c12", 64'(gid_log[12]), 64'(2));
    check("s1_gid_c13", 64'(gid_log[13]), 64'(0));
    n = 0;
    for (int s = 1; s < 14; s++) if (!pv_log[s] || !busy_log[s]) n++;
    check("s1_bubbles", 64'(n), 64'(0));

    // single requester: 10 beats back to back, then idle
    restart();
    push_beats(1, 10, -1);
    en = 3'b010;
    hs0 = hs_total;
    n = 0;
    for (int s = 0; s < 13; s++) begin
      step(); gid_log[s] = int'(last_gid); busy_log[s] = last_busy; pv_log[s] = last_pop_valid;
      if (s >= 1 && s <= 10 && (gid_log[s] != 1 || !pv_log[s])) n++;
    end
    check("s2_beats", 64'(hs_total - hs0), 64'(10));
    check("s2_gid_or_bubble", 64'(n), 64'(0));
    check("s2_busy_end", 64'(busy_log[12]), 64'(0));

    // EOP on third beat of stream 0 hands over to stream 2
    restart();
    push_beats(0, 6, 2);
    push_beats(2, 8, -1);
    en = 3'b101;
    for (int s = 0; s < 10; s++) begin step(); gid_log[s] = int'(last_gid); end
    check("s3_gid_c3", 64'(gid_log[3]), 64'(0));
    check("s3_gid_c4", 64'(gid_log[4]), 64'(2));
    check("s3_gid_c7", 64'(gid_log[7]), 64'(2));
    check("s3_gid_c8", 64'(gid_log[8]), 64'(0));

    // five cycles of back-pressure in the middle of stream 0's burst
    restart();
    for (int k = 0; k < NB; k++) push_beats(k, 20, -1);
    en = '1;
    repeat (3) step();
    ready_ctl = 0;
    hs0 = hs_total;
    step();
    held = last_pop_data;
    n = 0;
    for (int s = 0; s < 4; s++) begin
      step();
      if (last_gid != 0 || last_pop_data != held || last_ready != 0) n++;
    end
    check("s4_stall_stable", 64'(n), 64'(0));
    check("s4_stall_no_beat", 64'(hs_total - hs0), 64'(0));
    ready_ctl = 1;
    step(); check("s4_resume_gid_a", 64'(last_gid), 64'(0));
    step(); check("s4_resume_gid_b", 64'(last_gid), 64'(0));
    step(); check("s4_next_gid", 64'(last_gid), 64'(1));

    // stream 2 drops valid mid-burst while stream 0 waits
    restart();
    push_beats(2, 10, -1);
    push_beats(0, 10, -1);
    en = 3'b100;
    step();
    en = 3'b101;
    step(); step();
    en = 3'b001;
    step();
    check("s5_drop_valid", 64'(last_pop_valid), 64'(0));
    check("s5_drop_data", 64'(last_pop_data), 64'(0));
    step();
    check("s5_next_gid", 64'(last_gid), 64'(0));
    check("s5_next_busy", 64'(last_busy), 64'(1));

    // synchronous clear mid-burst
    restart();
    push_beats(1, 10, -1);
    push_beats(2, 10, -1);
    en = 3'b110;
    step(); step();
    check("s6_pre_clear_gid", 64'(last_gid), 64'(1));
    clear_ctl = 1;
    step();
    check("s6_clear_ready", 64'(last_ready), 64'(0));
    clear_ctl = 0;
    step();
    check("s6_post_busy", 64'(last_busy), 64'(0));
    check("s6_post_gid", 64'(last_gid), 64'(0));
    step();
    check("s6_first_gid", 64'(last_gid), 64'(1));

    // asynchronous reset mid-burst
    en = '1;
    push_beats(0, 10, -1);
    repeat (3) step();
    async_reset_mid("s7_rst");
    en = 3'b110;
    step();
    check("s7_post_busy", 64'(last_busy), 64'(0));
    step();
    check("s7_first_gid", 64'(last_gid), 64'(1));

    // randomized traffic
    restart();
    eop_pct = 20;
    for (int s = 0; s < 2000; s++) begin
      for (int k = 0; k < NB; k++) begin
        en[k] = ($urandom_range(99) < 80);
        if (src_q[k].size() < 3) push_beats(k, 6, -1);
      end
      ready_ctl = ($urandom_range(99) < 75);
      clear_ctl = ($urandom_range(99) < 1);
      step();
      if (s == 1000) async_reset_mid("rand_rst");
    end
    clear_ctl = 0;
    check("exp_q_empty", 64'(exp_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
